// File: rtl/simon_input_conditioner.sv
// simon_input_conditioner
//   Turns a raw, bouncing push-button and four raw pattern switches into the
//   clean strobe/data pair the Simon game core expects. The button is
//   synchronized and debounced. Each accepted press produces exactly one pclk
//   pulse. The switch value is captured when the press is accepted and held
//   until the button is released.
//
// Ports
//   clk      in   system clock, all state updates on its rising edge
//   rst      in   synchronous, active-high reset
//   btn_raw  in   asynchronous bouncing push-button, active-high
//   sw_raw   in   [3:0] asynchronous pattern switches
//   pclk     out  registered press pulse, HIGH_CYCLES wide
//   pattern  out  [3:0] registered switch value (frozen while busy)
//   busy     out  high whenever the press sequencer is not idle
//
// Parameters
//   DB_CYCLES     stable cycles (1..2^20-1) before a button level change is accepted
//   SETUP_CYCLES  cycles (1..255) pattern is frozen before pclk rises
//   HIGH_CYCLES   pclk high width in cycles (1..255)

module simon_input_conditioner #(
    parameter int unsigned DB_CYCLES    = 500000,
    parameter int unsigned SETUP_CYCLES = 4,
    parameter int unsigned HIGH_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [3:0] sw_raw,
    output logic       pclk,
    output logic [3:0] pattern,
    output logic       busy
);

    localparam logic [19:0] DB_LAST    = 20'(DB_CYCLES - 1);
    localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0]  HIGH_LAST  = 8'(HIGH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        WAIT_REL
    } state_t;

    // ---------------- two-flop synchronizers ----------------
    logic [1:0] btn_sync;
    logic [3:0] sw_sync1;
    logic [3:0] sw_s;
    logic       btn_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync <= '0;
            sw_sync1 <= '0;
            sw_s     <= '0;
        end else begin
            btn_sync <= {btn_sync[0], btn_raw};
            sw_sync1 <= sw_raw;
            sw_s     <= sw_sync1;
        end
    end

    assign btn_s = btn_sync[1];

    // ---------------- debounce ----------------
    // The counter only runs while btn_s disagrees with the accepted level.
    // Any agreement restarts it, so only an uninterrupted run of DB_CYCLES
    // mismatching cycles flips btn_db.
    logic [19:0] db_count;
    logic        btn_db;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_count <= '0;
            btn_db   <= 1'b0;
        end else if (btn_s == btn_db) begin
            db_count <= '0;
        end else if (db_count == DB_LAST) begin
            btn_db   <= btn_s;
            db_count <= '0;
        end else begin
            db_count <= db_count + 20'd1;
        end
    end

    // ---------------- press sequencer ----------------
    state_t     state, state_next;
    logic [7:0] phase, phase_next;
    logic [3:0] pattern_next;
    logic       pclk_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            pattern <= '0;
            pclk    <= 1'b0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            pattern <= pattern_next;
            pclk    <= pclk_next;
        end
    end

    always_comb begin
        state_next   = state;
        phase_next   = phase;
        pattern_next = pattern;

        unique case (state)
            IDLE: begin
                // Track the switches continuously. The value taken on the
                // edge that leaves IDLE is the captured pattern.
                pattern_next = sw_s;
                if (btn_db) begin
                    state_next = SETUP;
                    phase_next = '0;
                end
            end
            SETUP: begin
                if (phase == SETUP_LAST) begin
                    state_next = HIGH;
                    phase_next = '0;
                end else begin
                    phase_next = phase + 8'd1;
                end
            end
            HIGH: begin
                if (phase == HIGH_LAST) begin
                    state_next = WAIT_REL;
                    phase_next = '0;
                end else begin
                    phase_next = phase + 8'd1;
                end
            end
            WAIT_REL: begin
                if (!btn_db) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase

        // pclk is registered from the next state, so it is high for exactly
        // the cycles the sequencer spends in HIGH without an extra cycle of lag.
        pclk_next = (state_next == HIGH);
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_simon_input_conditioner.sv
`timescale 1ns/1ps

module tb_simon_input_conditioner;

    localparam int unsigned DB    = 4;
    localparam int unsigned SETUP = 2;
    localparam int unsigned HIGH  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic [3:0] sw_raw;
    logic       pclk;
    logic [3:0] pattern;
    logic       busy;

    int unsigned checks;
    int unsigned errors;
    int unsigned pulses;
    int unsigned width;
    logic        prev_pclk;

    simon_input_conditioner #(
        .DB_CYCLES   (DB),
        .SETUP_CYCLES(SETUP),
        .HIGH_CYCLES (HIGH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .sw_raw (sw_raw),
        .pclk   (pclk),
        .pattern(pattern),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later. Every pclk pulse is counted and
    // its width checked, unless reset cut it short.
    task automatic step();
        @(posedge clk);
        #1;
        if (pclk && !prev_pclk) begin
            pulses++;
            width = 0;
        end
        if (pclk) width++;
        if (!pclk && prev_pclk && !rst) check("pulse_width", width, HIGH);
        prev_pclk = pclk;
    endtask

    task automatic wait_idle(input int unsigned max);
        int unsigned n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        check("idle_reached", 32'(busy), 32'(0));
    endtask

    logic [3:0] pats [3];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        pulses    = 0;
        width     = 0;
        prev_pclk = 1'b0;
        rst       = 1'b1;
        btn_raw   = 1'b0;
        sw_raw    = 4'b0000;
        pats[0]   = 4'b0001;
        pats[1]   = 4'b0110;
        pats[2]   = 4'b1111;

        // Reset state
        repeat (3) step();
        check("rst_pclk",    32'(pclk),    32'(0));
        check("rst_pattern", 32'(pattern), 32'(0));
        check("rst_busy",    32'(busy),    32'(0));

        // Basic press, pattern 1010 (last reset edge is edge 0)
        rst     = 1'b0;
        sw_raw  = 4'b1010;
        btn_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 2) check("t1_pattern_e2", 32'(pattern), 32'(4'b0000));
            if (k == 3) check("t1_pattern_e3", 32'(pattern), 32'(4'b1010));
            check("t1_pclk", 32'(pclk), 32'(k >= 9 && k <= 11));
            check("t1_busy", 32'(busy), 32'(k >= 7));
            if (k == 14) btn_raw = 1'b0;
        end
        step();
        check("t1_busy_e21", 32'(busy), 32'(0));
        check("t1_pulses", pulses, 1);

        // Bounce: 3-cycle highs never get through the debouncer
        for (int unsigned k = 0; k < 30; k++) begin
            btn_raw = ((k / 3) % 2) == 0;
            step();
            check("t2_pclk", 32'(pclk), 32'(0));
            check("t2_busy", 32'(busy), 32'(0));
        end
        btn_raw = 1'b0;
        repeat (8) step();
        check("t2_busy_end", 32'(busy), 32'(0));
        check("t2_pulses", pulses, 1);

        // Switch change during HIGH is ignored until back in IDLE
        btn_raw = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            check("t3_pclk", 32'(pclk), 32'(k >= 9 && k <= 11));
            if (k >= 9 && k <= 17) check("t3_pattern_frozen", 32'(pattern), 32'(4'b1010));
            if (k == 16) check("t3_busy_e16", 32'(busy), 32'(1));
            if (k == 17) check("t3_busy_e17", 32'(busy), 32'(0));
            if (k == 18) check("t3_pattern_new", 32'(pattern), 32'(4'b0100));
            if (k == 9)  sw_raw  = 4'b0100;
            if (k == 10) btn_raw = 1'b0;
        end
        check("t3_pulses", pulses, 2);

        // Early release right after the press is accepted
        repeat (3) step();
        btn_raw = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            check("t4_pclk", 32'(pclk), 32'(k >= 9 && k <= 11));
            check("t4_busy", 32'(busy), 32'(k >= 7 && k <= 13));
            if (k == 7) btn_raw = 1'b0;
        end
        check("t4_pulses", pulses, 3);

        // Reset during HIGH with the button still held
        repeat (3) step();
        sw_raw  = 4'b0011;
        btn_raw = 1'b1;
        for (int k = 1; k <= 9; k++) step();
        check("t5_pclk_before", 32'(pclk),    32'(1));
        check("t5_pattern_cap", 32'(pattern), 32'(4'b0011));
        rst = 1'b1;
        step();
        check("t5_rst_pclk",    32'(pclk),    32'(0));
        check("t5_rst_pattern", 32'(pattern), 32'(0));
        check("t5_rst_busy",    32'(busy),    32'(0));
        rst = 1'b0;
        for (int k = 11; k <= 23; k++) begin
            step();
            check("t5_pclk", 32'(pclk), 32'(k >= 19 && k <= 21));
            check("t5_busy", 32'(busy), 32'(k >= 17));
            if (k == 19) check("t5_pattern", 32'(pattern), 32'(4'b0011));
        end
        btn_raw = 1'b0;
        wait_idle(30);
        check("t5_pulses", pulses, 5);

        // Three presses, each with its own captured pattern
        for (int unsigned p = 0; p < 3; p++) begin
            repeat (3) step();
            sw_raw  = pats[p];
            btn_raw = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                step();
                check("t6_pclk", 32'(pclk), 32'(k >= 9 && k <= 11));
                if (k == 9) check("t6_pattern", 32'(pattern), 32'(pats[p]));
                if (k == 7) sw_raw = ~pats[p];
            end
            btn_raw = 1'b0;
            wait_idle(30);
        end
        check("t6_pulses", pulses, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
